// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory handshake, redirect input and decode handoff.
// master = ifetch, slave = memory/decode/branch-resolution side.
interface ifetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [6:0]  if_opcode;
   logic        fetch_fault;

   modport master (
      output imem_req_valid, imem_addr, if_valid, if_pc, if_instr, if_opcode, fetch_fault,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr, if_opcode, fetch_fault,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/ifetch.sv
// rv32i instruction fetch: one outstanding imem request, redirect squashing,
// sticky fault and halt on a misaligned redirect target.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst_n,
   ifetch_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD, HALT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] if_pc_q;
   logic [31:0] if_instr_q;
   logic        fault_q;
   logic        redir;
   logic        redir_bad;

   assign redir     = bus.redirect_valid;
   assign redir_bad = redir && (bus.redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         if_pc_q    <= 32'h0;
         if_instr_q <= 32'h0;
         fault_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            HALT: state <= HALT;
            default: begin
               if (redir_bad) begin
                  fault_q <= 1'b1;
                  state   <= HALT;
               end else begin
                  if (redir)
                     pc <= bus.redirect_pc;
                  case (state)
                     // A request accepted alongside a redirect fetched the old pc: squash its reply.
                     REQ:  if (bus.imem_req_ready) state <= redir ? DROP : WAIT;
                     WAIT: begin
                        if (redir)
                           state <= bus.imem_rsp_valid ? REQ : DROP;
                        else if (bus.imem_rsp_valid) begin
                           if_instr_q <= bus.imem_rsp_data;
                           if_pc_q    <= pc;
                           pc         <= pc + 32'd4;
                           state      <= HOLD;
                        end
                     end
                     DROP: if (bus.imem_rsp_valid) state <= REQ;
                     HOLD: if (redir || bus.if_ready) state <= REQ;
                     default: state <= state;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.imem_req_valid = (state == REQ);
   assign bus.imem_addr      = pc;
   assign bus.if_valid       = (state == HOLD);
   assign bus.if_pc          = if_pc_q;
   assign bus.if_instr       = if_instr_q;
   assign bus.if_opcode      = if_instr_q[6:0];
   assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a negedge-driven memory model per DUT, one task per scenario.
module tb_ifetch;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ifetch_if bus ();
   ifetch_if bus_w ();

   ifetch #(.RESET_PC(32'h0000_0100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return ~a ^ 32'h1357_9BDF;
   endfunction

   // Main memory: reply mem_delay cycles after the accepting edge.
   int          mem_delay;
   logic        pending;
   int          cnt;
   logic [31:0] paddr;

   always @(negedge clk) begin
      if (!rst_n) begin
         pending            <= 1'b0;
         bus.imem_rsp_valid <= 1'b0;
      end else begin
         bus.imem_rsp_valid <= 1'b0;
         if (pending) begin
            if (cnt == 0) begin
               bus.imem_rsp_valid <= 1'b1;
               bus.imem_rsp_data  <= word(paddr);
               pending            <= 1'b0;
            end else
               cnt <= cnt - 1;
         end
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            pending <= 1'b1;
            cnt     <= mem_delay - 1;
            paddr   <= bus.imem_addr;
         end
      end
   end

   // Wrap DUT memory: fixed one-cycle reply.
   logic        w_hs;
   logic [31:0] w_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         w_hs                 <= 1'b0;
         bus_w.imem_rsp_valid <= 1'b0;
      end else begin
         bus_w.imem_rsp_valid <= w_hs;
         bus_w.imem_rsp_data  <= word(w_addr);
         w_hs                 <= bus_w.imem_req_valid && bus_w.imem_req_ready;
         w_addr               <= bus_w.imem_addr;
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      mem_delay          = 1;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", bus.imem_req_valid); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b exp 0", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h exp 0", bus.if_pc); end
      checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got %h exp 0", bus.if_instr); end
      checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", bus.fetch_fault); end
      checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp 00000100", bus.imem_addr); end
      checks++; if (bus_w.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr_w got %h exp fffffffc", bus_w.imem_addr); end
      rst_n = 1'b1;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid got %b exp 0", bus.imem_req_valid); end
   endtask

   task automatic test_fetch;
      logic [31:0] exp_a;
      logic [31:0] exp_w;
      do_reset;
      bus.if_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick;
         checks++;
         if (bus.imem_req_valid !== (c % 3 == 1)) begin errors++; $display("FAIL fetch_req_valid c%0d got %b", c, bus.imem_req_valid); end
         if (c % 3 == 1) begin
            exp_a = 32'h100 + 32'(4 * ((c - 1) / 3));
            checks++; if (bus.imem_addr !== exp_a) begin errors++; $display("FAIL fetch_addr c%0d got %h exp %h", c, bus.imem_addr, exp_a); end
         end
         checks++;
         if (bus.if_valid !== (c % 3 == 0)) begin errors++; $display("FAIL fetch_if_valid c%0d got %b", c, bus.if_valid); end
         if (c % 3 == 0) begin
            exp_a = 32'h100 + 32'(4 * (c / 3 - 1));
            exp_w = word(exp_a);
            checks++; if (bus.if_pc !== exp_a) begin errors++; $display("FAIL fetch_if_pc c%0d got %h exp %h", c, bus.if_pc, exp_a); end
            checks++; if (bus.if_instr !== exp_w) begin errors++; $display("FAIL fetch_if_instr c%0d got %h exp %h", c, bus.if_instr, exp_w); end
            checks++; if (bus.if_opcode !== exp_w[6:0]) begin errors++; $display("FAIL fetch_opcode c%0d got %h exp %h", c, bus.if_opcode, exp_w[6:0]); end
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset;
      bus.if_ready = 1'b0;
      tick;
      tick;
      tick;
      for (int k = 0; k < 5; k++) begin
         checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL bp_if_valid k%0d got %b exp 1", k, bus.if_valid); end
         checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL bp_if_pc k%0d got %h exp 00000100", k, bus.if_pc); end
         checks++; if (bus.if_instr !== word(32'h100)) begin errors++; $display("FAIL bp_if_instr k%0d got %h exp %h", k, bus.if_instr, word(32'h100)); end
         checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid k%0d got %b exp 0", k, bus.imem_req_valid); end
         tick;
      end
      bus.if_ready = 1'b1;
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b exp 1", bus.if_valid); end
      tick;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_resume_req got %b exp 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL bp_resume_addr got %h exp 00000104", bus.imem_addr); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got %b exp 0", bus.if_valid); end
   endtask

   task automatic test_redirect_wait;
      do_reset;
      bus.if_ready = 1'b1;
      mem_delay    = 3;
      tick;
      tick;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      tick;
      bus.redirect_valid = 1'b0;
      mem_delay          = 1;
      for (int c = 3; c <= 4; c++) begin
         checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_valid c%0d got %b exp 0", c, bus.imem_req_valid); end
         checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_valid c%0d got %b exp 0", c, bus.if_valid); end
         tick;
      end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_req5 got %b exp 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rw_addr5 got %h exp 00000200", bus.imem_addr); end
      tick;
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rw_valid6 got %b exp 0", bus.if_valid); end
      tick;
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rw_valid7 got %b exp 1", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h200) begin errors++; $display("FAIL rw_if_pc got %h exp 00000200", bus.if_pc); end
      checks++; if (bus.if_instr !== word(32'h200)) begin errors++; $display("FAIL rw_if_instr got %h exp %h", bus.if_instr, word(32'h200)); end
   endtask

   task automatic test_redirect_rsp;
      do_reset;
      bus.if_ready = 1'b1;
      tick;
      tick;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h300;
      tick;
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rr_req got %b exp 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'h300) begin errors++; $display("FAIL rr_addr got %h exp 00000300", bus.imem_addr); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rr_discard got %b exp 0", bus.if_valid); end
      tick;
      tick;
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rr_valid got %b exp 1", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h300) begin errors++; $display("FAIL rr_if_pc got %h exp 00000300", bus.if_pc); end
      checks++; if (bus.if_instr !== word(32'h300)) begin errors++; $display("FAIL rr_if_instr got %h exp %h", bus.if_instr, word(32'h300)); end
   endtask

   task automatic test_redirect_hold_req;
      do_reset;
      bus.if_ready = 1'b1;
      tick;
      tick;
      tick;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h400;
      tick;
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b exp 0", bus.if_valid); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rh_req got %b exp 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'h400) begin errors++; $display("FAIL rh_addr got %h exp 00000400", bus.imem_addr); end
      bus.redirect_pc = 32'h500;
      tick;
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rq_drop_req got %b exp 0", bus.imem_req_valid); end
      tick;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rq_req got %b exp 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'h500) begin errors++; $display("FAIL rq_addr got %h exp 00000500", bus.imem_addr); end
   endtask

   task automatic test_fault;
      do_reset;
      bus.if_ready = 1'b1;
      tick;
      tick;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h202;
      tick;
      bus.redirect_valid = 1'b0;
      checks++; if (bus.fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_rise got %b exp 1", bus.fetch_fault); end
      checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL fault_pc got %h exp 00000100", bus.imem_addr); end
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0 || bus.fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL halt k%0d req %b if_valid %b fault %b exp 0 0 1", k, bus.imem_req_valid, bus.if_valid, bus.fetch_fault);
         end
         tick;
      end
      rst_n = 1'b0;
      tick;
      checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", bus.fetch_fault); end
      rst_n = 1'b1;
      tick;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL fault_restart_req got %b exp 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL fault_restart_addr got %h exp 00000100", bus.imem_addr); end
   endtask

   task automatic test_wrap;
      do_reset;
      tick;
      checks++; if (bus_w.imem_req_valid !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first req %b addr %h exp 1 fffffffc", bus_w.imem_req_valid, bus_w.imem_addr); end
      tick;
      tick;
      checks++; if (bus_w.if_valid !== 1'b1 || bus_w.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_if valid %b pc %h exp 1 fffffffc", bus_w.if_valid, bus_w.if_pc); end
      checks++; if (bus_w.if_instr !== word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got %h exp %h", bus_w.if_instr, word(32'hFFFF_FFFC)); end
      tick;
      checks++; if (bus_w.imem_req_valid !== 1'b1 || bus_w.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_second req %b addr %h exp 1 00000000", bus_w.imem_req_valid, bus_w.imem_addr); end
   endtask

   initial begin
      checks               = 0;
      errors               = 0;
      mem_delay            = 1;
      rst_n                = 1'b0;
      bus.imem_req_ready   = 1'b1;
      bus.redirect_valid   = 1'b0;
      bus.redirect_pc      = 32'h0;
      bus.if_ready         = 1'b1;
      bus_w.imem_req_ready = 1'b1;
      bus_w.redirect_valid = 1'b0;
      bus_w.redirect_pc    = 32'h0;
      bus_w.if_ready       = 1'b1;
      test_reset;
      test_fetch;
      test_backpressure;
      test_redirect_wait;
      test_redirect_rsp;
      test_redirect_hold_req;
      test_fault;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
